// File: rtl/sobel_hls_pixel_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : sobel_hls_pixel_addr_gen
// Purpose  : Raster-scan frame-buffer address generator for the Sobel
//            datapath. Walks a frame row by row, column by column, and emits
//            addr = base + row*width + col (modulo 2^ADDR_W) through a
//            valid/ready handshake with end-of-line / end-of-frame flags.
//            ADDR_W must be at least ROW_W+COL_W.
// Ports    : ap_clk, ap_rst_n (async, active low)
//            start, img_width, img_height, base_addr  - frame request
//            addr, addr_valid, addr_ready, eol, last  - address stream
//            busy, done                               - frame status
// Revision : 1.0 - initial release
// ============================================================================
module sobel_hls_pixel_addr_gen #(
    parameter int ROW_W  = 9,
    parameter int COL_W  = 11,
    parameter int ADDR_W = 20
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start,
    input  logic [COL_W-1:0]  img_width,
    input  logic [ROW_W-1:0]  img_height,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              eol,
    output logic              last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [ROW_W-1:0]    row;
    logic [COL_W-1:0]    col;
    logic [COL_W-1:0]    width_q;
    logic [ROW_W-1:0]    height_q;
    logic [ADDR_W-1:0]   base_q;

    logic                fire;
    logic [ROW_W-1:0]    next_row;
    logic [COL_W-1:0]    next_col;
    logic [ROW_W+COL_W-1:0] next_prod;
    logic [ADDR_W-1:0]   next_addr;
    logic                next_eol;
    logic                next_last;

    // Next raster position and its address are formed ahead of the edge so
    // the registered outputs advance on the same edge as the handshake.
    always_comb begin
        fire      = addr_valid && addr_ready;
        next_row  = row;
        next_col  = col + COL_W'(1);
        // eol already encodes col == width-1 for the current address
        if (eol) begin
            next_row = row + ROW_W'(1);
            next_col = '0;
        end
        next_prod = (ROW_W+COL_W)'(next_row) * (ROW_W+COL_W)'(width_q);
        next_addr = base_q + ADDR_W'(next_prod) + ADDR_W'(next_col);
        next_eol  = (next_col == width_q - COL_W'(1));
        next_last = next_eol && (next_row == height_q - ROW_W'(1));
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            width_q    <= '0;
            height_q   <= '0;
            base_q     <= '0;
            addr       <= '0;
            addr_valid <= 1'b0;
            eol        <= 1'b0;
            last       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if ((img_width != '0) && (img_height != '0)) begin
                            width_q    <= img_width;
                            height_q   <= img_height;
                            base_q     <= base_addr;
                            row        <= '0;
                            col        <= '0;
                            addr       <= base_addr;
                            addr_valid <= 1'b1;
                            eol        <= (img_width == COL_W'(1));
                            last       <= (img_width == COL_W'(1)) &&
                                          (img_height == ROW_W'(1));
                            busy       <= 1'b1;
                            state      <= RUN;
                        end else begin
                            // Empty frame: nothing to emit, just acknowledge
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // start is deliberately ignored here
                    if (fire) begin
                        if (last) begin
                            addr_valid <= 1'b0;
                            eol        <= 1'b0;
                            last       <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            row  <= next_row;
                            col  <= next_col;
                            addr <= next_addr;
                            eol  <= next_eol;
                            last <= next_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/sobel_hls_pixel_addr_gen.md
Name: sobel_hls_pixel_addr_gen

Overview:
- Raster-scan address generator for the Sobel datapath. Walks a frame row by row, column by column.
- For each pixel it emits addr = base + row*width + col, using the 9-bit-row by 11-bit-width unsigned product.
- Feeds the frame-buffer read/write port through a valid/ready handshake, with end-of-line and end-of-frame flags.
- One instance per frame-buffer stream; control comes from the top-level start/done sequencer.

Parameters:
- ROW_W, 9, width of the row counter and img_height.
- COL_W, 11, width of the column counter and img_width.
- ADDR_W, 20, width of base_addr and addr. Must be ≥ ROW_W+COL_W.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle frame start request.
- img_width  in  COL_W  pixels per line; sampled when start is accepted.
- img_height  in  ROW_W  lines per frame; sampled when start is accepted.
- base_addr  in  ADDR_W  frame base address; sampled when start is accepted.
- addr  out  ADDR_W  current pixel address.
- addr_valid  out  1  addr/eol/last are valid.
- addr_ready  in  1  consumer accepts the current address.
- eol  out  1  current address is the last column of its line.
- last  out  1  current address is the final pixel of the frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset (ap_rst_n=0, any time, including mid-frame):
  - State goes to IDLE; row, col, addr, and latched width/height/base clear to 0.
  - addr_valid, eol, last, busy and done are all 0.
  - Reset takes effect immediately. No partial frame resumes after release.
- FSM states: IDLE, RUN.
- IDLE, start=1, img_width≠0 and img_height≠0:
  - Latch width, height and base; row=0, col=0.
  - Next cycle: addr=base_addr, addr_valid=1, eol=(width==1), last=(width==1 && height==1), busy=1.
  - Go to RUN. Latency from start to first addr_valid is 1 cycle.
- IDLE, start=1, img_width==0 or img_height==0:
  - No addresses are emitted; remain in IDLE.
  - done pulses 1 cycle later.
- RUN, fire (addr_valid && addr_ready):
  - If last: addr_valid=0, busy=0, done=1 next cycle; go to IDLE.
  - Else if col==width-1: col=0, row=row+1.
  - Else: col=col+1.
  - The new addr/eol/last are registered on the same edge, so a continuously ready consumer sees one address per cycle with no bubbles.
- RUN, addr_valid=1 and addr_ready=0: addr, eol and last are held stable, and counters do not move.
- start while busy=1 is ignored. No re-latch of width, height or base.
- Arithmetic:
  - The product row*width is unsigned, ROW_W+COL_W bits, computed combinationally from the next-row value.
  - Sum = base + product + col, zero-extended, truncated to ADDR_W (modulo 2^ADDR_W). No overflow flag.
- eol/last alignment: eol=(col==width-1), last=eol && (row==height-1). Both are registered with addr and valid only while addr_valid=1.
- done is high for exactly 1 cycle per accepted start, and is never asserted in the same cycle as addr_valid.
- Input changes to img_width, img_height or base_addr during RUN have no effect.

Test Plan:
- base=0, width=4, height=3, ready held 1 → addr 0..11 on 12 consecutive cycles; eol at 3, 7, 11; last at 11; done 1 cycle after the fire of 11; busy high for 12 cycles.
- Same frame, ready toggling 1,0,0,1,… → each address held stable across ready=0 cycles; sequence, eol and last unchanged; no address skipped or duplicated.
- base=0xFFFFE, width=2, height=2 → addr 0xFFFFE, 0xFFFFF, 0x00000, 0x00001 (wrap); last on 0x00001.
- width=0, height=5, start → no addr_valid; done 1 cycle later; busy stays 0. Repeat with width=1, height=1 → single addr=base with eol=1, last=1.
- width=2047, height=511, base=0 → final address 1046016 with last=1, eol=1; 1046017 total fires.
- Mid-frame: start pulse at pixel 5 → ignored. Then assert ap_rst_n=0 at pixel 7 → outputs 0 immediately. After release, a new start with a 3×2 frame produces addr 0..5.
